// File: rtl/id_ex_pipeline_register.sv
// Decode-to-execute pipeline register for the 5-stage RV32I core.
// Captures operands (with same-cycle write-back bypass), immediate, PC and
// control on each edge; supports stall (hold), flush (bubble insert) and
// two saturating debug event counters.
module id_ex_pipeline_register #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_d,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_d,
  input  logic [XLEN-1:0]  rd1_d,
  input  logic [XLEN-1:0]  rd2_d,
  input  logic [XLEN-1:0]  imm_d,
  input  logic [XLEN-1:0]  pc_d,
  input  logic [XLEN-1:0]  pc4_d,
  input  logic [8:0]       ctrl_d,
  input  logic             we_w,
  input  logic [4:0]       rd_w,
  input  logic [XLEN-1:0]  result_w,
  input  logic             stall,
  input  logic             flush,
  output logic             valid_e,
  output logic [4:0]       rs1_e,
  output logic [4:0]       rs2_e,
  output logic [4:0]       rd_e,
  output logic [XLEN-1:0]  rd1_e,
  output logic [XLEN-1:0]  rd2_e,
  output logic [XLEN-1:0]  imm_e,
  output logic [XLEN-1:0]  pc_e,
  output logic [XLEN-1:0]  pc4_e,
  output logic [8:0]       ctrl_e,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             valid_e_q, valid_e_d;
  logic [4:0]       rs1_e_q, rs1_e_d;
  logic [4:0]       rs2_e_q, rs2_e_d;
  logic [4:0]       rd_e_q, rd_e_d;
  logic [XLEN-1:0]  rd1_e_q, rd1_e_d;
  logic [XLEN-1:0]  rd2_e_q, rd2_e_d;
  logic [XLEN-1:0]  imm_e_q, imm_e_d;
  logic [XLEN-1:0]  pc_e_q, pc_e_d;
  logic [XLEN-1:0]  pc4_e_q, pc4_e_d;
  logic [8:0]       ctrl_e_q, ctrl_e_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // The register file writes on the same edge, so decode may have read the
  // old value; substitute the write-back result when it targets rs1/rs2.
  // x0 never bypasses: it always reads zero.
  logic byp1, byp2;
  assign byp1 = we_w && (rd_w != 5'd0) && (rd_w == rs1_d);
  assign byp2 = we_w && (rd_w != 5'd0) && (rd_w == rs2_d);

  // Next-state selection: flush > stall (hold) > load; counters saturate.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    valid_e_d   = valid_e_q;
    rs1_e_d     = rs1_e_q;
    rs2_e_d     = rs2_e_q;
    rd_e_d      = rd_e_q;
    rd1_e_d     = rd1_e_q;
    rd2_e_d     = rd2_e_q;
    imm_e_d     = imm_e_q;
    pc_e_d      = pc_e_q;
    pc4_e_d     = pc4_e_q;
    ctrl_e_d    = ctrl_e_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (flush) begin
      // Bubble: kill side effects and addresses; data fields are don't-care
      // and simply hold.
      valid_e_d = 1'b0;
      ctrl_e_d  = '0;
      rd_e_d    = '0;
      rs1_e_d   = '0;
      rs2_e_d   = '0;
      if (valid_e_q && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
    end else if (stall) begin
      if (valid_e_q && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
    end else begin
      valid_e_d = valid_d;
      rs1_e_d   = rs1_d;
      rs2_e_d   = rs2_d;
      rd_e_d    = rd_d;
      rd1_e_d   = byp1 ? result_w : rd1_d;
      rd2_e_d   = byp2 ? result_w : rd2_d;
      imm_e_d   = imm_d;
      pc_e_d    = pc_d;
      pc4_e_d   = pc4_d;
      ctrl_e_d  = valid_d ? ctrl_d : 9'd0;
    end
  end

  // State register with synchronous active-low reset to an all-zero bubble.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      valid_e_q   <= 1'b0;
      rs1_e_q     <= '0;
      rs2_e_q     <= '0;
      rd_e_q      <= '0;
      rd1_e_q     <= '0;
      rd2_e_q     <= '0;
      imm_e_q     <= '0;
      pc_e_q      <= '0;
      pc4_e_q     <= '0;
      ctrl_e_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_e_q   <= valid_e_d;
      rs1_e_q     <= rs1_e_d;
      rs2_e_q     <= rs2_e_d;
      rd_e_q      <= rd_e_d;
      rd1_e_q     <= rd1_e_d;
      rd2_e_q     <= rd2_e_d;
      imm_e_q     <= imm_e_d;
      pc_e_q      <= pc_e_d;
      pc4_e_q     <= pc4_e_d;
      ctrl_e_q    <= ctrl_e_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign valid_e   = valid_e_q;
  assign rs1_e     = rs1_e_q;
  assign rs2_e     = rs2_e_q;
  assign rd_e      = rd_e_q;
  assign rd1_e     = rd1_e_q;
  assign rd2_e     = rd2_e_q;
  assign imm_e     = imm_e_q;
  assign pc_e      = pc_e_q;
  assign pc4_e     = pc4_e_q;
  assign ctrl_e    = ctrl_e_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Bench for id_ex_pipeline_register: directed steps then randomized cycles,
// all checked against a behavioural model of the E-stage contents.
module tb_id_ex_pipeline_register;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_d;
  logic [4:0]       rs1_d, rs2_d, rd_d;
  logic [XLEN-1:0]  rd1_d, rd2_d, imm_d, pc_d, pc4_d;
  logic [8:0]       ctrl_d;
  logic             we_w;
  logic [4:0]       rd_w;
  logic [XLEN-1:0]  result_w;
  logic             stall, flush;
  logic             valid_e;
  logic [4:0]       rs1_e, rs2_e, rd_e;
  logic [XLEN-1:0]  rd1_e, rd2_e, imm_e, pc_e, pc4_e;
  logic [8:0]       ctrl_e;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  id_ex_pipeline_register #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .valid_d(valid_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .pc_d(pc_d), .pc4_d(pc4_d),
    .ctrl_d(ctrl_d), .we_w(we_w), .rd_w(rd_w), .result_w(result_w),
    .stall(stall), .flush(flush),
    .valid_e(valid_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc_e(pc_e), .pc4_e(pc4_e),
    .ctrl_e(ctrl_e), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model of the E stage.
  int          m_valid, m_rs1, m_rs2, m_rd, m_ctrl;
  int unsigned m_rd1, m_rd2, m_imm, m_pc, m_pc4;
  int          m_scnt, m_fcnt;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned operand(input int rs, input int unsigned regval);
    if (we_w && rd_w != 0 && int'(rd_w) == rs) return result_w;
    return regval;
  endfunction

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_step();
    if (!rst) begin
      m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0;
      m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc = 0; m_pc4 = 0;
      m_scnt = 0; m_fcnt = 0;
    end else if (flush) begin
      if (m_valid == 1) m_fcnt = (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
      m_valid = 0; m_ctrl = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
    end else if (stall) begin
      if (m_valid == 1) m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
    end else begin
      m_valid = valid_d;
      m_rs1 = rs1_d; m_rs2 = rs2_d; m_rd = rd_d;
      m_rd1 = operand(rs1_d, rd1_d);
      m_rd2 = operand(rs2_d, rd2_d);
      m_imm = imm_d; m_pc = pc_d; m_pc4 = pc4_d;
      m_ctrl = valid_d ? int'(ctrl_d) : 0;
    end
  endtask

  task automatic compare_all();
    chk("valid_e",   32'(valid_e),   32'(m_valid));
    chk("rs1_e",     32'(rs1_e),     32'(m_rs1));
    chk("rs2_e",     32'(rs2_e),     32'(m_rs2));
    chk("rd_e",      32'(rd_e),      32'(m_rd));
    chk("ctrl_e",    32'(ctrl_e),    32'(m_ctrl));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
    chk("pc_e",      pc_e,           m_pc);
    chk("pc4_e",     pc4_e,          m_pc4);
    chk("imm_e",     imm_e,          m_imm);
    chk("rd1_e",     rd1_e,          m_rd1);
    chk("rd2_e",     rd2_e,          m_rd2);
  endtask

  // One clock: update model, let the edge pass, sample 1 time unit later.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    rst = 1'b1; valid_d = 1'b0; rs1_d = '0; rs2_d = '0; rd_d = '0;
    rd1_d = '0; rd2_d = '0; imm_d = '0; pc_d = '0; pc4_d = '0; ctrl_d = '0;
    we_w = 1'b0; rd_w = '0; result_w = '0; stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0;
    m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc = 0; m_pc4 = 0;
    m_scnt = 0; m_fcnt = 0;
    #2;

    // Reset with a fully-asserted valid instruction on the inputs.
    rst = 1'b0; valid_d = 1'b1; ctrl_d = 9'h1FF; rd1_d = 32'hDEAD; pc_d = 32'h40;
    tick(); tick();
    chk("reset_valid", 32'(valid_e), 32'd0);
    chk("reset_ctrl", 32'(ctrl_e), 32'd0);
    chk("reset_pc", pc_e, 32'd0);

    // First load after reset.
    idle_inputs();
    valid_d = 1'b1; rs1_d = 5'd5; rd1_d = 32'h1234; ctrl_d = 9'h181;
    tick();
    chk("load_rd1", rd1_e, 32'h1234);
    chk("load_ctrl", 32'(ctrl_e), 32'h181);
    chk("load_valid", 32'(valid_e), 32'd1);

    // Same-cycle write-back bypass onto both operands.
    rs1_d = 5'd7; rs2_d = 5'd7; rd1_d = 32'hAAAA; rd2_d = 32'hAAAA;
    we_w = 1'b1; rd_w = 5'd7; result_w = 32'h5555;
    tick();
    chk("byp_rd1", rd1_e, 32'h5555);
    chk("byp_rd2", rd2_e, 32'h5555);
    // x0 must never bypass.
    rs1_d = 5'd0; rd1_d = 32'h0; rd_w = 5'd0;
    tick();
    chk("byp_x0", rd1_e, 32'h0);
    // Write enable low: no bypass.
    rs1_d = 5'd7; rd1_d = 32'hAAAA; rd_w = 5'd7; we_w = 1'b0;
    tick();
    chk("byp_we0", rd1_e, 32'hAAAA);

    // Stall hold from a clean reset.
    idle_inputs(); rst = 1'b0; tick();
    idle_inputs(); valid_d = 1'b1; pc_d = 32'h100; ctrl_d = 9'h1C0;
    tick();
    pc_d = 32'h104; stall = 1'b1;
    tick(); tick(); tick();
    chk("stall_pc", pc_e, 32'h100);
    chk("stall_cnt3", 32'(stall_cnt), 32'd3);
    stall = 1'b0;
    tick();
    chk("release_pc", pc_e, 32'h104);
    chk("release_ctrl", 32'(ctrl_e), 32'h1C0);

    // Flush together with stall: flush wins, counts once.
    flush = 1'b1; stall = 1'b1;
    tick();
    chk("flush_valid", 32'(valid_e), 32'd0);
    chk("flush_ctrl", 32'(ctrl_e), 32'd0);
    chk("flush_cnt1", 32'(flush_cnt), 32'd1);
    chk("flush_scnt", 32'(stall_cnt), 32'd3);
    tick();
    chk("flush_bubble_cnt", 32'(flush_cnt), 32'd1);

    // Invalid decode never carries control.
    idle_inputs(); valid_d = 1'b0; ctrl_d = 9'h1FF;
    tick();
    chk("inv_ctrl", 32'(ctrl_e), 32'd0);
    chk("inv_valid", 32'(valid_e), 32'd0);

    // Counter saturation, then reset clears it.
    rst = 1'b0; tick();
    idle_inputs(); valid_d = 1'b1; ctrl_d = 9'h100; tick();
    stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) chk("sat_reach", 32'(stall_cnt), 32'hF);
    end
    chk("sat_hold", 32'(stall_cnt), 32'hF);
    rst = 1'b0; tick();
    chk("sat_reset", 32'(stall_cnt), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(99) >= 3);
      flush    = ($urandom_range(99) < 10);
      stall    = ($urandom_range(99) < 30);
      valid_d  = ($urandom_range(99) < 80);
      rs1_d    = 5'($urandom_range(3));
      rs2_d    = 5'($urandom_range(3));
      rd_d     = 5'($urandom);
      rd1_d    = $urandom; rd2_d = $urandom; imm_d = $urandom;
      pc_d     = $urandom; pc4_d = pc_d + 32'd4;
      ctrl_d   = 9'($urandom);
      we_w     = 1'($urandom);
      rd_w     = 5'($urandom_range(3));
      result_w = $urandom;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_pipeline_register.md
Name: id_ex_pipeline_register

Overview:
- Decode-to-execute pipeline register of the 5-stage RV32I core.
- Captures the two operands read from the register file, plus the immediate, PC and decoded control fields, on every clk edge.
- Applies the same-cycle write-back bypass. The register file writes on the edge, so decode reads stale data when write-back targets rs1/rs2 in the same cycle; this block corrects that.
- Supports stall (hold), flush (bubble insert) and two event counters read by debug.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 16, width of stall/flush event counters.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- valid_d  input  1  decode stage holds a real instruction.
- rs1_d  input  5  source register 1 address.
- rs2_d  input  5  source register 2 address.
- rd_d  input  5  destination register address.
- rd1_d  input  XLEN  register file read data 1.
- rd2_d  input  XLEN  register file read data 2.
- imm_d  input  XLEN  sign-extended immediate.
- pc_d  input  XLEN  instruction PC.
- pc4_d  input  XLEN  PC+4.
- ctrl_d  input  9  {RegWrite, MemWrite, Branch, Jump, ALUSrc, ResultSrc[1:0], ALUControl[2:0] truncated to 2}. Bit 8 is RegWrite, bit 7 is MemWrite.
- we_w  input  1  write-back RegWrite (same signal that drives the register file write enable).
- rd_w  input  5  write-back destination address.
- result_w  input  XLEN  write-back data.
- stall  input  1  hold E-stage contents (downstream not ready).
- flush  input  1  replace E-stage contents with a bubble.
- valid_e  output  1  E-stage instruction valid.
- rs1_e, rs2_e, rd_e  output  5 each  registered addresses, for the forwarding unit.
- rd1_e, rd2_e  output  XLEN each  registered operands after bypass.
- imm_e, pc_e, pc4_e  output  XLEN each  registered copies of the decode values.
- ctrl_e  output  9  registered control.
- stall_cnt  output  CNT_W  count of cycles in which stall held a valid instruction.
- flush_cnt  output  CNT_W  count of flush events that killed a valid instruction.

Behaviour:
- All state updates on posedge clk only. No asynchronous paths; outputs come directly from flops.
- Priority at each edge: reset > flush > stall > load.
- Reset (rst==0):
  - All outputs, including both counters, go to 0.
  - valid_e=0 and ctrl_e=0, so the E-stage holds a bubble with no side effects.
- Flush:
  - valid_e<=0, ctrl_e<=0, rd_e<=0, rs1_e<=0, rs2_e<=0.
  - Data fields (rd1_e, rd2_e, imm_e, pc_e, pc4_e) hold their previous values; their contents are don't-care.
  - Flush overrides stall in the same cycle.
- Stall (flush==0): every output holds its value. The bypass is not applied to held values.
- Load (stall==0, flush==0):
  - Capture all *_d inputs into the matching *_e outputs.
  - valid_e<=valid_d.
  - If valid_d==0, ctrl_e<=0, regardless of ctrl_d.
- Bypass, applied on load only:
  - rd1_e <= result_w if (we_w && rd_w!=0 && rd_w==rs1_d); otherwise rd1_d.
  - rd2_e is selected the same way, using rs2_d.
  - rs1_d==0 always captures rd1_d, which is 0 from the register file, even if rd_w==0 with we_w=1.
- Latency: exactly 1 cycle from decode inputs to E outputs when not stalled.
- stall_cnt:
  - Increments when stall==1 && flush==0 && valid_e==1 && rst==1.
  - Saturates at all-ones and does not wrap.
- flush_cnt:
  - Increments when flush==1 && valid_e==1 && rst==1.
  - Saturates at all-ones.
  - A flush of a bubble does not count.
- Reset asserted while stalled: reset wins; the held contents are discarded.
- Stall release: the captured data is whatever is on the *_d inputs in the first unstalled cycle. The upstream stage must be held together with this one.

Test Plan:
- Reset, then a load:
  - Stimulus: rst=0 for 2 cycles, with ctrl_d=9'h1FF and valid_d=1 applied.
  - Required: all outputs 0, both counters 0.
  - Then rst=1, valid_d=1, rs1_d=5, rd1_d=32'h1234, ctrl_d=9'h181.
  - Required, next cycle: rd1_e=32'h1234, ctrl_e=9'h181, valid_e=1.
- Write-back bypass:
  - Stimulus: rs1_d=7, rs2_d=7, rd1_d=rd2_d=32'hAAAA, we_w=1, rd_w=7, result_w=32'h5555.
  - Required: rd1_e=rd2_e=32'h5555.
  - Repeat with rd_w=0 and rs1_d=0: required rd1_e=0.
  - Repeat with we_w=0: required rd1_e=32'hAAAA.
- Stall hold:
  - Stimulus: load pc_d=32'h100, then stall=1 for 3 cycles while pc_d changes to 32'h104.
  - Required: pc_e stays 32'h100 and stall_cnt=3.
  - Then stall=0: required pc_e=32'h104.
- Flush with stall:
  - Stimulus: a valid instruction in E with ctrl_e=9'h1C0; assert flush=1 and stall=1 together.
  - Required, next cycle: valid_e=0, ctrl_e=0, flush_cnt=1, stall_cnt unchanged.
  - A second flush, now with valid_e=0: required flush_cnt stays 1.
- Invalid decode:
  - Stimulus: valid_d=0, ctrl_d=9'h1FF.
  - Required: ctrl_e=0, valid_e=0.
- Counter saturation:
  - Stimulus: CNT_W=4, hold a valid instruction stalled for 20 cycles.
  - Required: stall_cnt reaches 4'hF and stays there.
  - Then reset: required 0.
